sseg_scan_ctrl: RTL and testbench

Scan controller for the 4-digit multiplexed seven-segment display. It holds a committed 16-bit BCD display value and time-multiplexes one nibble at a time onto the shared BCD-to-seven-segment decoder, driving the active-low anode selects. Each digit slot has a programmable dwell time and an anti-ghosting blank interval. Optional leading-zero blanking is supported. New values are accepted by a load/ack handshake and take effect only at frame boundaries, so a frame never shows a mix of old and new digits.

---
 rtl/sseg_scan_ctrl.sv | 143 ++++++++++++++
 tb/tb_sseg_scan_ctrl.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/sseg_scan_ctrl.sv
// Scan controller for a 4-digit multiplexed seven-segment display.
// Holds a committed BCD value and shows one digit per slot, with an all-off
// blank interval before each digit to avoid ghosting. New values are taken
// through a load/ack handshake and only become visible at frame boundaries.
module sseg_scan_ctrl #(
    parameter int unsigned DWELL = 12500,
    parameter int unsigned BLANK = 250,
    parameter int unsigned CW    = 17
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] value_in,
    input  logic        load,
    input  logic        lzb_en,
    output logic [3:0]  an,
    output logic [3:0]  digit_bcd,
    output logic        seg_blank,
    output logic        load_ack,
    output logic        frame_done
);

    localparam logic [CW-1:0] DwellLast = CW'(DWELL - 1);
    localparam logic [CW-1:0] BlankLast = CW'(BLANK - 1);

    typedef enum logic {
        StBlank,
        StShow
    } state_t;

    state_t         state_q, state_d;
    logic [1:0]     idx_q, idx_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [15:0]    shadow_q, shadow_d;
    logic [15:0]    pend_val_q, pend_val_d;
    logic           pend_q, pend_d;
    logic           lzb_q, lzb_d;

    logic           commit;
    logic           supp;
    logic           lit;
    logic [3:0]     an_d;
    logic [3:0]     digit_d;
    logic           seg_blank_d;
    logic           ack_d;
    logic           fd_d;

    // Next-state logic; outputs are derived from the next state so that the
    // registered outputs always describe the slot the FSM is currently in.
    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        cnt_d      = cnt_q + CW'(1);
        shadow_d   = shadow_q;
        pend_val_d = pend_val_q;
        pend_d     = pend_q;
        lzb_d      = lzb_q;
        ack_d      = 1'b0;
        fd_d       = 1'b0;

        // Last cycle of the last digit's SHOW slot closes the frame.
        commit = (state_q == StShow) && (idx_q == 2'd3) && (cnt_q == DwellLast);

        unique case (state_q)
            StBlank: begin
                if (cnt_q == BlankLast) begin
                    state_d = StShow;
                    cnt_d   = '0;
                end
            end
            StShow: begin
                if (cnt_q == DwellLast) begin
                    state_d = StBlank;
                    cnt_d   = '0;
                    idx_d   = idx_q + 2'd1;
                end
            end
            default: begin
                state_d = StBlank;
                cnt_d   = '0;
            end
        endcase

        if (commit) begin
            fd_d = 1'b1;
            // A load in the commit cycle itself bypasses the pending register.
            if (load || pend_q) begin
                shadow_d = load ? value_in : pend_val_q;
                lzb_d    = lzb_en;
                ack_d    = 1'b1;
                pend_d   = 1'b0;
            end
        end else if (load) begin
            pend_val_d = value_in;
            pend_d     = 1'b1;
        end

        digit_d = shadow_d[{idx_d, 2'b00} +: 4];

        // Digit k is a leading zero when it and every digit above it are zero.
        unique case (idx_d)
            2'd3:    supp = lzb_d && (shadow_d[15:12] == 4'd0);
            2'd2:    supp = lzb_d && (shadow_d[15:8] == 8'd0);
            2'd1:    supp = lzb_d && (shadow_d[15:4] == 12'd0);
            default: supp = 1'b0;
        endcase

        lit         = (state_d == StShow) && !supp;
        an_d        = lit ? ~(4'b0001 << idx_d) : 4'b1111;
        seg_blank_d = !lit;
    end

    // State and registered outputs; reset drops everything, including pending.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= StBlank;
            idx_q      <= 2'd0;
            cnt_q      <= '0;
            shadow_q   <= 16'd0;
            pend_val_q <= 16'd0;
            pend_q     <= 1'b0;
            lzb_q      <= 1'b0;
            an         <= 4'b1111;
            digit_bcd  <= 4'd0;
            seg_blank  <= 1'b1;
            load_ack   <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            cnt_q      <= cnt_d;
            shadow_q   <= shadow_d;
            pend_val_q <= pend_val_d;
            pend_q     <= pend_d;
            lzb_q      <= lzb_d;
            an         <= an_d;
            digit_bcd  <= digit_d;
            seg_blank  <= seg_blank_d;
            load_ack   <= ack_d;
            frame_done <= fd_d;
        end
    end

endmodule

// File: tb/tb_sseg_scan_ctrl.sv
// Bench for sseg_scan_ctrl with DWELL=4, BLANK=2 (24-cycle frames).
// Stimulus pushes cycle-stamped expectations; a negedge monitor pops and compares.
module tb_sseg_scan_ctrl;

    logic        clk;
    logic        rst;
    logic [15:0] value_in;
    logic        load;
    logic        lzb_en;
    logic [3:0]  an;
    logic [3:0]  digit_bcd;
    logic        seg_blank;
    logic        load_ack;
    logic        frame_done;

    sseg_scan_ctrl #(
        .DWELL(4),
        .BLANK(2),
        .CW   (3)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .value_in  (value_in),
        .load      (load),
        .lzb_en    (lzb_en),
        .an        (an),
        .digit_bcd (digit_bcd),
        .seg_blank (seg_blank),
        .load_ack  (load_ack),
        .frame_done(frame_done)
    );

    typedef struct packed {
        int         cyc;
        logic [3:0] an;
        logic [3:0] bcd;
        logic       blank;
        logic       ack;
        logic       fd;
    } exp_t;

    exp_t q[$];
    exp_t e;
    int   cyc;
    logic run;
    int   n_vec;
    int   n_bad;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) if (run) cyc <= cyc + 1;

    initial begin
        #100000;
        $display("FAIL watchdog: time limit reached at cyc=%0d", cyc);
        $fatal(1, "watchdog");
    end

    // Monitor: compare every expectation stamped for the current cycle.
    always @(negedge clk) begin
        if (run) begin
            while (q.size() > 0 && q[0].cyc <= cyc) begin
                e = q.pop_front();
                n_vec++;
                if (e.cyc != cyc) begin
                    n_bad++;
                    $display("FAIL missed cyc=%0d: sampled at cyc=%0d", e.cyc, cyc);
                end else if (an !== e.an || digit_bcd !== e.bcd || seg_blank !== e.blank ||
                             load_ack !== e.ack || frame_done !== e.fd) begin
                    n_bad++;
                    $display("FAIL scan cyc=%0d: got an=%b bcd=%h blank=%b ack=%b fd=%b, need an=%b bcd=%h blank=%b ack=%b fd=%b",
                             cyc, an, digit_bcd, seg_blank, load_ack, frame_done,
                             e.an, e.bcd, e.blank, e.ack, e.fd);
                end
            end
        end
    end

    task automatic push_cycle(input int c, input logic [3:0] a, input logic [3:0] b,
                              input logic bl, input logic ak, input logic f);
        exp_t x;
        x.cyc   = c;
        x.an    = a;
        x.bcd   = b;
        x.blank = bl;
        x.ack   = ak;
        x.fd    = f;
        q.push_back(x);
    endtask

    // Expand one frame: lit[k]=1 means digit k lights during its SHOW slot.
    task automatic push_frame(input int base, input logic [15:0] v, input logic [3:0] lit,
                              input logic ak, input logic f, input int ncyc);
        for (int i = 0; i < ncyc; i++) begin
            int         k;
            logic       on;
            logic [3:0] a;
            k  = i / 6;
            on = (i % 6 >= 2) && lit[k];
            a  = on ? ~(4'b0001 << k) : 4'b1111;
            push_cycle(base + i, a, v[4*k +: 4], !on, (i == 0) ? ak : 1'b0,
                       (i == 0) ? f : 1'b0);
        end
    endtask

    task automatic wait_cyc(input int c);
        while (cyc != c) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic pulse_load(input int c, input logic [15:0] v);
        wait_cyc(c);
        value_in = v;
        load     = 1'b1;
        @(posedge clk);
        #1;
        load = 1'b0;
    endtask

    initial begin
        rst      = 1'b1;
        value_in = 16'd0;
        load     = 1'b0;
        lzb_en   = 1'b0;
        run      = 1'b0;
        cyc      = 0;
        n_vec    = 0;
        n_bad    = 0;

        // Idle scan of the reset value: all zeros, no frame_done in frame 0.
        push_frame(0, 16'h0000, 4'b1111, 1'b0, 1'b0, 24);
        push_frame(24, 16'h0000, 4'b1111, 1'b0, 1'b1, 24);

        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        run = 1'b1;

        // Mid-frame load becomes visible only after the commit edge.
        push_frame(48, 16'h1234, 4'b1111, 1'b1, 1'b1, 24);
        pulse_load(30, 16'h1234);

        // Two loads before commit: last wins, single ack.
        push_frame(72, 16'h5678, 4'b1111, 1'b1, 1'b1, 24);
        pulse_load(50, 16'h1111);
        pulse_load(60, 16'h5678);

        // Leading-zero blanking of 0042 and of 0000.
        lzb_en = 1'b1;
        push_frame(96, 16'h0042, 4'b0011, 1'b1, 1'b1, 24);
        pulse_load(80, 16'h0042);
        push_frame(120, 16'h0000, 4'b0001, 1'b1, 1'b1, 24);
        pulse_load(100, 16'h0000);

        // Load exactly in the commit cycle (last SHOW cycle of digit 3).
        push_frame(144, 16'h9876, 4'b1111, 1'b1, 1'b1, 15);
        wait_cyc(142);
        lzb_en = 1'b0;
        pulse_load(143, 16'h9876);

        // Pending value then reset during SHOW of digit 2.
        pulse_load(150, 16'h4321);
        push_cycle(159, 4'b1111, 4'h0, 1'b1, 1'b0, 1'b0);
        push_cycle(160, 4'b1111, 4'h0, 1'b1, 1'b0, 1'b0);
        push_frame(161, 16'h0000, 4'b1111, 1'b0, 1'b0, 24);
        push_frame(185, 16'h0000, 4'b1111, 1'b0, 1'b1, 24);
        wait_cyc(159);
        rst = 1'b1;
        wait_cyc(161);
        rst = 1'b0;

        wait_cyc(209);
        while (q.size() > 0) begin
            e = q.pop_front();
            n_vec++;
            n_bad++;
            $display("FAIL unchecked cyc=%0d: expectation never compared", e.cyc);
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
